// File: rtl/hex_keypad_entry.sv
// 4x4 hex keypad scanner: column scan, scan-level debounce, accepted digits shift into a 16-bit value.
// Optional macro KEY_REPEAT_EN adds auto-repeat of a held key every REPEAT_SCANS full scans.
module hex_keypad_entry #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [15:0] value,
  output logic [3:0]  key_code,
  output logic        key_valid
);

  localparam int TickW = $clog2(SCAN_DIV);
  localparam logic [3:0] DebLast = 4'(DEBOUNCE_SCANS);

  if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15 || REPEAT_SCANS < 1) begin : g_badParams
    $error("hex_keypad_entry: parameter out of range");
  end

  typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_PRESSED, S_RELEASE} stateType;

  logic [3:0]       r_sync1, r_sync2;
  logic [TickW-1:0] r_tickCnt;
  logic [1:0]       r_colIdx;
  logic [1:0]       r_accCount;
  logic [3:0]       r_accCode;
  stateType         r_state, w_stateNext;
  logic [3:0]       r_cnt, w_cntNext, w_cntInc;
  logic [3:0]       r_cand, w_candNext;
  logic [15:0]      r_value;
  logic [3:0]       r_keyCode;
  logic             r_keyValid;
  logic             w_tick, w_scanDone, w_accept, w_none, w_single;
  logic [1:0]       w_colCount, w_colRow, w_accCount, w_sumCount;
  logic [2:0]       w_sum3;
  logic [3:0]       w_sumCode;
`ifdef KEY_REPEAT_EN
  localparam int RepW = $clog2(REPEAT_SCANS + 1);
  localparam logic [RepW-1:0] RepLast = RepW'(REPEAT_SCANS);
  logic [RepW-1:0] r_repCnt, w_repNext, w_repInc;
  assign w_repInc = r_repCnt + RepW'(1);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 4'hF;
      r_sync2 <= 4'hF;
    end else begin
      r_sync1 <= row;
      r_sync2 <= r_sync1;
    end
  end

  assign w_tick     = (r_tickCnt == TickW'(SCAN_DIV - 1));
  assign w_scanDone = w_tick && (r_colIdx == 2'd3);
  assign col        = ~(4'b0001 << r_colIdx);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tickCnt <= '0;
      r_colIdx  <= 2'd0;
    end else if (w_tick) begin
      r_tickCnt <= '0;
      r_colIdx  <= r_colIdx + 2'd1;
    end else begin
      r_tickCnt <= r_tickCnt + TickW'(1);
    end
  end

  // Key count saturates at 2 (MULTI); column 0 starts a fresh scan, column 3 closes it.
  always_comb begin
    w_colCount = 2'd0;
    w_colRow   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!r_sync2[i]) begin
        w_colRow = 2'(i);
        if (w_colCount != 2'd2) w_colCount = w_colCount + 2'd1;
      end
    end
    w_accCount = (r_colIdx == 2'd0) ? 2'd0 : r_accCount;
    w_sum3     = {1'b0, w_accCount} + {1'b0, w_colCount};
    w_sumCount = (w_sum3 >= 3'd2) ? 2'd2 : w_sum3[1:0];
    w_sumCode  = (w_accCount == 2'd0) ? {w_colRow, r_colIdx} : r_accCode;
  end

  assign w_none   = (w_sumCount == 2'd0);
  assign w_single = (w_sumCount == 2'd1);
  assign w_cntInc = r_cnt + 4'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_accCount <= 2'd0;
      r_accCode  <= 4'd0;
    end else if (w_tick) begin
      r_accCount <= w_sumCount;
      r_accCode  <= w_sumCode;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_candNext  = r_cand;
    w_accept    = 1'b0;
`ifdef KEY_REPEAT_EN
    w_repNext   = r_repCnt;
`endif
    if (w_scanDone) begin
`ifdef KEY_REPEAT_EN
      w_repNext = '0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_single) begin
            w_candNext = w_sumCode;
            w_cntNext  = 4'd1;
            if (DebLast == 4'd1) begin
              w_accept    = 1'b1;
              w_stateNext = S_PRESSED;
            end else begin
              w_stateNext = S_DEBOUNCE;
            end
          end
        end
        S_DEBOUNCE: begin
          if (w_single && (w_sumCode == r_cand)) begin
            w_cntNext = w_cntInc;
            if (w_cntInc == DebLast) begin
              w_accept    = 1'b1;
              w_stateNext = S_PRESSED;
            end
          end else begin
            w_cntNext   = 4'd0;
            w_stateNext = S_IDLE;
          end
        end
        S_PRESSED: begin
          if (w_none) begin
            if (DebLast == 4'd1) begin
              w_cntNext   = 4'd0;
              w_stateNext = S_IDLE;
            end else begin
              w_cntNext   = 4'd1;
              w_stateNext = S_RELEASE;
            end
          end
`ifdef KEY_REPEAT_EN
          else if (w_single && (w_sumCode == r_cand)) begin
            if (w_repInc == RepLast) w_accept = 1'b1;
            else w_repNext = w_repInc;
          end
`endif
        end
        S_RELEASE: begin
          if (w_none) begin
            w_cntNext = w_cntInc;
            if (w_cntInc == DebLast) begin
              w_cntNext   = 4'd0;
              w_stateNext = S_IDLE;
            end
          end else begin
            w_stateNext = S_PRESSED;
          end
        end
        default: w_stateNext = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_cand  <= 4'd0;
`ifdef KEY_REPEAT_EN
      r_repCnt <= '0;
`endif
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
      r_cand  <= w_candNext;
`ifdef KEY_REPEAT_EN
      r_repCnt <= w_repNext;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_value    <= 16'h0000;
      r_keyCode  <= 4'h0;
      r_keyValid <= 1'b0;
    end else begin
      r_keyValid <= w_accept;
      if (w_accept) begin
        r_value   <= {r_value[11:0], w_candNext};
        r_keyCode <= w_candNext;
      end
    end
  end

  assign value     = r_value;
  assign key_code  = r_keyCode;
  assign key_valid = r_keyValid;

endmodule
